// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared defaults and counter sizing for the hazard scoreboard
package hazard_pkg;

    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_ALU_LAT     = 2;
    localparam int DEF_LOAD_LAT    = 3;
    localparam int DEF_FWD_SLACK   = 2;
    localparam int DEF_STALL_CNT_W = 16;

    // Busy counters must hold the longest latency (a load).
    function automatic int cnt_width(input int load_lat);
        return (load_lat < 1) ? 1 : $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage request/decision bundle between decoder and scoreboard
interface hazard_scoreboard_if import hazard_pkg::*; #(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                   id_valid;
    logic [AW-1:0]          src_a;
    logic [AW-1:0]          src_b;
    logic                   use_a;
    logic                   use_b;
    logic                   is_ctrl;
    logic [AW-1:0]          dest;
    logic                   reg_write;
    logic                   mem_read;
    logic                   flush;
    logic                   PCWrite;
    logic                   DecodeRegWrite;
    logic                   MuxControl;
    logic                   issue;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, src_a, src_b, use_a, use_b, is_ctrl, dest, reg_write, mem_read, flush,
        input  PCWrite, DecodeRegWrite, MuxControl, issue, stall_count
    );

    modport slave (
        input  id_valid, src_a, src_b, use_a, use_b, is_ctrl, dest, reg_write, mem_read, flush,
        output PCWrite, DecodeRegWrite, MuxControl, issue, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_reg_busy_counter.sv
// rtl/hazard_scoreboard_reg_busy_counter.sv - per-register remaining-latency counter
module reg_busy_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A new producer overrides the ongoing countdown; idle counters hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage RAW hazard detector with per-register busy counters
module hazard_scoreboard import hazard_pkg::*; #(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int ALU_LAT     = DEF_ALU_LAT,
    parameter int LOAD_LAT    = DEF_LOAD_LAT,
    parameter int FORWARD_EN  = 1,
    parameter int FWD_SLACK   = DEF_FWD_SLACK,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    hazard_scoreboard_if.slave sb
);
    localparam int CW = cnt_width(LOAD_LAT);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [CW-1:0]          cnt [NUM_REGS];
    logic [CW-1:0]          thr_w;
    logic [CW-1:0]          lat_w;
    logic                   live_w;
    logic                   hazard_w;
    logic                   issue_w;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    assign cnt[0] = '0;

    // Control consumers resolve in decode, so forwarding cannot cover them.
    always_comb begin
        thr_w    = (sb.is_ctrl || (FORWARD_EN == 0)) ? '0 : CW'(FWD_SLACK);
        lat_w    = sb.mem_read ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        live_w   = sb.id_valid && !sb.flush;
        hazard_w = live_w && ((sb.use_a && (cnt[sb.src_a] > thr_w)) ||
                              (sb.use_b && (cnt[sb.src_b] > thr_w)));
        issue_w  = live_w && !hazard_w;
    end

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_busy
            logic load_w;
            assign load_w = issue_w && sb.reg_write && (sb.dest == AW'(r));
            reg_busy_counter #(.W(CW)) u_cnt (
                .clk_i      (Clk),
                .rst_i      (Reset),
                .load_i     (load_w),
                .load_val_i (lat_w),
                .cnt_o      (cnt[r])
            );
        end
    endgenerate

    always_comb begin
        stall_d = stall_q;
        if (hazard_w && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign sb.PCWrite        = !hazard_w;
    assign sb.DecodeRegWrite = !hazard_w;
    assign sb.MuxControl     = !hazard_w;
    assign sb.issue          = issue_w;
    assign sb.stall_count    = stall_q;

endmodule
